pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_hz_sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encodings and widths for the pipeline hazard sequencer.
// Benches import this to decode o_state.
package pipeline_hazard_ctrl_pkg;

  localparam int HZ_STATE_W  = 2;
  localparam int WAIT_CNT_W  = 16;
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [HZ_STATE_W-1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_FLUSH      = 2'd2,
    HZ_MEM_WAIT   = 2'd3
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hz_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Clear has priority over enable.
module hz_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; owns no datapath.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
//
// state         | meaning
// HZ_RUN        | normal flow, hazards/branches/busy accepted
// HZ_LOAD_STALL | one cycle after a load-use bubble, hazard ignored
// HZ_FLUSH      | IF/ID cleared while the flush down-counter runs
// HZ_MEM_WAIT   | whole pipe held until data memory is ready
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_WAIT_MAX = 255,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  i_mem_hazard,
  input  logic                  i_branch_taken,
  input  logic                  i_mem_busy,
  output logic                  o_if_stall,
  output logic                  o_id_stall,
  output logic                  o_ex_stall,
  output logic                  o_me_stall,
  output logic                  o_id_clr,
  output logic                  o_ex_clr,
  output logic                  o_mem_timeout,
  output logic [HZ_STATE_W-1:0] o_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      o_stall_cycles,
  output logic [CNT_W-1:0]      o_flush_events
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_FULL   = FLUSH_CNT_W'(FLUSH_CYCLES);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_TC      = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

  hz_state_e              state_d, state_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic                   pend_d, pend_q;
  logic                   timeout_d, timeout_q;
  logic                   stall_all, stall_front;
  logic                   id_clr, ex_clr;
  logic                   br_accept;
  logic                   wait_en, wait_exit;
  logic [WAIT_CNT_W-1:0]  wait_cnt;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pend_d      = pend_q;
    timeout_d   = timeout_q;
    stall_all   = 1'b0;
    stall_front = 1'b0;
    id_clr      = 1'b0;
    ex_clr      = 1'b0;
    br_accept   = 1'b0;
    wait_en     = 1'b0;
    wait_exit   = 1'b0;
    if (clr) begin
      id_clr = 1'b1;
      ex_clr = 1'b1;
    end else begin
      unique case (state_q)
        HZ_RUN, HZ_LOAD_STALL: begin
          state_d = HZ_RUN;
          if (i_mem_busy) begin
            stall_all = 1'b1;
            state_d   = HZ_MEM_WAIT;
          end else if (i_branch_taken) begin
            id_clr      = 1'b1;
            ex_clr      = 1'b1;
            br_accept   = 1'b1;
            flush_cnt_d = FLUSH_RELOAD;
            state_d     = (FLUSH_CYCLES == 1) ? HZ_RUN : HZ_FLUSH;
          end else if (i_mem_hazard && (state_q == HZ_RUN)) begin
            stall_front = 1'b1;
            state_d     = HZ_LOAD_STALL;
          end
        end
        HZ_FLUSH: begin
          // Busy preempts this flush cycle; the count still owes it.
          if (i_mem_busy) begin
            stall_all = 1'b1;
            pend_d    = 1'b1;
            state_d   = HZ_MEM_WAIT;
          end else if (i_branch_taken) begin
            id_clr      = 1'b1;
            br_accept   = 1'b1;
            flush_cnt_d = FLUSH_RELOAD;
          end else begin
            id_clr      = 1'b1;
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
            if (flush_cnt_q == FLUSH_CNT_W'(1)) state_d = HZ_RUN;
          end
        end
        HZ_MEM_WAIT: begin
          // No clear has been issued for a branch seen here, so owe the full count.
          if (i_branch_taken) begin
            pend_d      = 1'b1;
            flush_cnt_d = FLUSH_FULL;
            br_accept   = 1'b1;
          end
          if (i_mem_busy) begin
            stall_all = 1'b1;
            wait_en   = 1'b1;
            if (wait_cnt >= WAIT_TC) timeout_d = 1'b1;
          end else begin
            wait_exit = 1'b1;
            pend_d    = 1'b0;
            state_d   = (pend_q || i_branch_taken) ? HZ_FLUSH : HZ_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= HZ_RUN;
      flush_cnt_q <= '0;
      pend_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
      timeout_q   <= timeout_d;
    end
  end

  hz_sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk   (clk),
    .clr   (clr | wait_exit),
    .en    (wait_en),
    .o_cnt (wait_cnt)
  );

  assign o_if_stall    = stall_all | stall_front;
  assign o_id_stall    = stall_all | stall_front;
  assign o_ex_stall    = stall_all;
  assign o_me_stall    = stall_all;
  assign o_id_clr      = id_clr;
  assign o_ex_clr      = ex_clr;
  assign o_mem_timeout = timeout_q;
  assign o_state       = state_q;

`ifdef HAZARD_PERF_EN
  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (clr),
    .en    (o_if_stall),
    .o_cnt (o_stall_cycles)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (clr),
    .en    (br_accept),
    .o_cnt (o_flush_events)
  );
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule
